// File: rtl/id_decode_stage_if.sv
// Decode-stage bus: IF/ID instruction, WB write port and ID/EX outputs.
// master = surrounding pipeline, slave = decode stage.
interface id_decode_stage_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr_i;
    logic              instr_vld_i;
    logic              flush_i;
    logic              wb_en_i;
    logic [3:0]        wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              stall_o;
    logic [4:0]        OpCode;
    logic [31:0]       Rd;
    logic [DATA_W-1:0] Rs;
    logic [DATA_W-1:0] Rt;
    logic [31:0]       Rsi;

    modport master (
        output instr_i, instr_vld_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        input  stall_o, OpCode, Rd, Rs, Rt, Rsi
    );
    modport slave (
        input  instr_i, instr_vld_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        output stall_o, OpCode, Rd, Rs, Rt, Rsi
    );
endinterface

// File: rtl/id_decode_stage.sv
// Instruction decode: register file with write-first bypass, immediate
// sign-extension and single-bubble load-use interlock.
module id_decode_stage #(
    parameter int         NREG    = 16,
    parameter int         DATA_W  = 32,
    parameter logic [4:0] LOAD_OP = 5'd9,
    parameter logic [4:0] NOP_OP  = 5'd0
) (
    input  logic              clk,
    input  logic              rst,
    id_decode_stage_if.slave  bus
);
    typedef enum logic {ISSUE, STALL} state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [NREG];
    logic              ld_vld;
    logic [3:0]        ld_rd;

    logic [4:0]        op;
    logic [3:0]        rd, rs, rt;
    logic [14:0]       imm;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              hazard, kill, issue, wr;

    assign op  = bus.instr_i[31:27];
    assign rd  = bus.instr_i[26:23];
    assign rs  = bus.instr_i[22:19];
    assign rt  = bus.instr_i[18:15];
    assign imm = bus.instr_i[14:0];

    assign wr = bus.wb_en_i && (bus.wb_addr_i != 4'd0);

    // Write-first: a register being written this cycle reads as the new value.
    assign rs_val = (rs == 4'd0)                  ? '0 :
                    (wr && bus.wb_addr_i == rs)   ? bus.wb_data_i : rf[rs];
    assign rt_val = (rt == 4'd0)                  ? '0 :
                    (wr && bus.wb_addr_i == rt)   ? bus.wb_data_i : rf[rt];

    assign hazard = bus.instr_vld_i && ld_vld && (ld_rd != 4'd0) &&
                    ((ld_rd == rs) || (ld_rd == rt));
    assign kill   = bus.flush_i || !bus.instr_vld_i;
    // In STALL the load tracker has already dropped, so the held instruction goes.
    assign issue  = rst && !kill && ((state == STALL) || !hazard);

    always_comb begin
        bus.OpCode  = NOP_OP;
        bus.Rd      = '0;
        bus.Rs      = '0;
        bus.Rt      = '0;
        bus.Rsi     = '0;
        bus.stall_o = rst && (state == ISSUE) && !kill && hazard;
        if (issue) begin
            bus.OpCode = op;
            bus.Rd     = {28'd0, rd};
            bus.Rs     = rs_val;
            bus.Rt     = rt_val;
            bus.Rsi    = {{17{imm[14]}}, imm};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            state  <= ISSUE;
            ld_vld <= 1'b0;
            ld_rd  <= 4'd0;
        end else begin
            if (wr) rf[bus.wb_addr_i] <= bus.wb_data_i;
            ld_vld <= issue && (op == LOAD_OP);
            ld_rd  <= rd;
            case (state)
                ISSUE:   if (bus.stall_o) state <= STALL;
                default: state <= ISSUE;
            endcase
        end
    end
endmodule
